// File: rtl/bp_me_pkg.sv
// bp_me_pkg: CCE<->memory message formats and helpers shared by the memory-endpoint blocks.
package bp_me_pkg;

    localparam int paddr_width_p     = 40;
    localparam int cce_block_width_p = 512;
    localparam int lce_id_width_p    = 2;
    localparam int lce_assoc_p       = 8;

    localparam int lg_lce_assoc_lp   = $clog2(lce_assoc_p);
    localparam int lg_block_bytes_lp = $clog2(cce_block_width_p / 8);

    typedef enum logic [3:0] {
        e_cce_mem_rd    = 4'd0,
        e_cce_mem_wr    = 4'd1,
        e_cce_mem_uc_rd = 4'd2,
        e_cce_mem_uc_wr = 4'd3
    } bp_cce_mem_cmd_type_e;

    typedef enum logic [2:0] {
        e_mem_size_1  = 3'd0,
        e_mem_size_2  = 3'd1,
        e_mem_size_4  = 3'd2,
        e_mem_size_8  = 3'd3,
        e_mem_size_16 = 3'd4,
        e_mem_size_32 = 3'd5,
        e_mem_size_64 = 3'd6
    } bp_mem_size_e;

    typedef struct packed {
        logic [lce_id_width_p-1:0]  lce_id;
        logic [lg_lce_assoc_lp-1:0] way_id;
    } bp_cce_mem_payload_s;

    typedef struct packed {
        bp_cce_mem_cmd_type_e     msg_type;
        logic [paddr_width_p-1:0] addr;
        bp_mem_size_e             size;
        bp_cce_mem_payload_s      payload;
    } bp_cce_mem_header_s;

    typedef struct packed {
        bp_cce_mem_header_s           header;
        logic [cce_block_width_p-1:0] data;
    } bp_cce_mem_msg_s;

    localparam int cce_mem_header_width_lp = $bits(bp_cce_mem_header_s);
    localparam int cce_mem_msg_width_lp    = $bits(bp_cce_mem_msg_s);

    typedef enum logic [1:0] {
        e_delay_ready,
        e_delay_wait,
        e_delay_resp
    } bp_cce_mem_delay_state_e;

    // Anything that is not an explicit write (including unknown types) behaves as a read.
    function automatic logic is_mem_wr(input bp_cce_mem_cmd_type_e t);
        return (t == e_cce_mem_wr) || (t == e_cce_mem_uc_wr);
    endfunction

endpackage

// File: rtl/bp_cce_mem_delay_storage.sv
// bp_cce_mem_delay_storage: 1R1W synchronous block array; a read colliding with a write returns the write data.
module bp_cce_mem_delay_storage #(
    parameter int els_p   = 64,
    parameter int width_p = 512,
    localparam int lg_els_lp = $clog2(els_p)
) (
    input  logic                 clk_i,
    input  logic                 w_v_i,
    input  logic [lg_els_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]   w_data_i,
    input  logic                 r_v_i,
    input  logic [lg_els_lp-1:0] r_addr_i,
    output logic [width_p-1:0]   r_data_o
);

    logic [width_p-1:0] mem_q [els_p];
    logic [width_p-1:0] r_data_q;

    // Contents deliberately have no reset: they survive a reset of the surrounding model.
    always_ff @(posedge clk_i) begin
        if (w_v_i) mem_q[w_addr_i] <= w_data_i;
        if (r_v_i) r_data_q <= (w_v_i && w_addr_i == r_addr_i) ? w_data_i : mem_q[r_addr_i];
    end

    assign r_data_o = r_data_q;

endmodule

// File: rtl/bp_cce_mem_delay_model.sv
// bp_cce_mem_delay_model: single-outstanding memory endpoint answering each mem_cmd
// with a mem_resp a fixed latency_p+1 cycles after accept.
module bp_cce_mem_delay_model
    import bp_me_pkg::*;
#(
    parameter int mem_els_p = 64,
    parameter int latency_p = 4,
    localparam int lg_els_lp = $clog2(mem_els_p),
    localparam int cnt_w_lp  = (latency_p > 0) ? $clog2(latency_p + 1) : 1
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
    input  logic                            mem_cmd_v_i,
    output logic                            mem_cmd_ready_o,
    output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
    output logic                            mem_resp_v_o,
    input  logic                            mem_resp_yumi_i,
    output logic                            busy_o
);

    bp_cce_mem_msg_s         cmd;
    bp_cce_mem_header_s      hdr_q;
    bp_cce_mem_delay_state_e state_q;
    logic [cnt_w_lp-1:0]     cnt_q;
    logic                    rd_q, ready_q, resp_v_q, busy_q;
    logic                    accept, is_wr;
    logic [lg_els_lp-1:0]    idx;
    logic [cce_block_width_p-1:0] rdata;

    assign cmd    = mem_cmd_i;
    assign accept = ready_q & mem_cmd_v_i;
    assign is_wr  = is_mem_wr(cmd.header.msg_type);
    assign idx    = cmd.header.addr[lg_block_bytes_lp +: lg_els_lp];

    bp_cce_mem_delay_storage #(
        .els_p   (mem_els_p),
        .width_p (cce_block_width_p)
    ) storage (
        .clk_i    (clk_i),
        .w_v_i    (accept & is_wr),
        .w_addr_i (idx),
        .w_data_i (cmd.data),
        .r_v_i    (accept & ~is_wr),
        .r_addr_i (idx),
        .r_data_o (rdata)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= e_delay_ready;
            cnt_q    <= '0;
            hdr_q    <= '0;
            rd_q     <= 1'b0;
            ready_q  <= 1'b1;
            resp_v_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                e_delay_ready: if (mem_cmd_v_i) begin
                    hdr_q   <= cmd.header;
                    rd_q    <= ~is_wr;
                    cnt_q   <= cnt_w_lp'(latency_p);
                    ready_q <= 1'b0;
                    busy_q  <= 1'b1;
                    if (latency_p == 0) begin
                        state_q  <= e_delay_resp;
                        resp_v_q <= 1'b1;
                    end else begin
                        state_q <= e_delay_wait;
                    end
                end
                e_delay_wait: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == cnt_w_lp'(1)) begin
                        state_q  <= e_delay_resp;
                        resp_v_q <= 1'b1;
                    end
                end
                e_delay_resp: if (mem_resp_yumi_i) begin
                    state_q  <= e_delay_ready;
                    resp_v_q <= 1'b0;
                    ready_q  <= 1'b1;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state_q  <= e_delay_ready;
                    resp_v_q <= 1'b0;
                    ready_q  <= 1'b1;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    // Read data stays stable in RESP because storage only captures at accept.
    assign mem_resp_o      = resp_v_q ? {hdr_q, rd_q ? rdata : {cce_block_width_p{1'b0}}} : '0;
    assign mem_resp_v_o    = resp_v_q;
    assign mem_cmd_ready_o = ready_q;
    assign busy_o          = busy_q;

    yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        mem_resp_yumi_i |-> mem_resp_v_o);

endmodule

// File: tb/tb_bp_cce_mem_delay_model.sv
// tb_bp_cce_mem_delay_model: random and directed checks of the delay model against a
// block-array reference, using a latency-4 and a latency-0 instance.
module tb_bp_cce_mem_delay_model;
    import bp_me_pkg::*;

    localparam int W  = cce_mem_msg_width_lp;
    localparam int HW = cce_mem_header_width_lp;
    localparam int BW = cce_block_width_p;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [W-1:0] cmd = '0;
    logic cmd_v = 1'b0, yumi = 1'b0, sel = 1'b0;
    logic [W-1:0] resp4, resp0, resp;
    logic rdy4, rdy0, rv4, rv0, busy4, busy0, rdy, rv, busy;
    int tests = 0, fails = 0, cyc = 0, acc_cyc = 0;

    logic [BW-1:0] mem_m [2][64];
    bit known [2][64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bp_cce_mem_delay_model #(.mem_els_p(64), .latency_p(4)) u_dut4 (
        .clk_i(clk), .reset_n_i(rst_n), .mem_cmd_i(cmd), .mem_cmd_v_i(cmd_v & ~sel),
        .mem_cmd_ready_o(rdy4), .mem_resp_o(resp4), .mem_resp_v_o(rv4),
        .mem_resp_yumi_i(yumi & ~sel), .busy_o(busy4));

    bp_cce_mem_delay_model #(.mem_els_p(64), .latency_p(0)) u_dut0 (
        .clk_i(clk), .reset_n_i(rst_n), .mem_cmd_i(cmd), .mem_cmd_v_i(cmd_v & sel),
        .mem_cmd_ready_o(rdy0), .mem_resp_o(resp0), .mem_resp_v_o(rv0),
        .mem_resp_yumi_i(yumi & sel), .busy_o(busy0));

    assign rdy  = sel ? rdy0 : rdy4;
    assign rv   = sel ? rv0 : rv4;
    assign busy = sel ? busy0 : busy4;
    assign resp = sel ? resp0 : resp4;

    function automatic logic [BW-1:0] rnd_blk();
        logic [BW-1:0] b;
        for (int i = 0; i < BW / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [39:0] rnd_addr();
        return {8'($urandom), 32'($urandom)};
    endfunction

    // One full transaction on the selected instance; the model decides what must come back.
    task automatic xact(input logic [3:0] t, input logic [39:0] a, input logic [BW-1:0] d,
                        input logic [4:0] pl, input int hold, input string nm);
        logic [HW-1:0] hdr;
        logic [BW-1:0] exp_d;
        logic [W-1:0] snap;
        int k, s, ix, lat;
        bit wr, chk;
        s   = sel ? 1 : 0;
        lat = sel ? 0 : 4;
        ix  = int'((a / 64) % 64);
        wr  = (t == 4'd1) || (t == 4'd3);
        chk = wr || known[s][ix];
        exp_d = wr ? '0 : mem_m[s][ix];
        hdr = {t, a, 3'($urandom_range(0, 6)), pl};
        cmd = {hdr, d};
        cmd_v = 1'b1;
        k = 0;
        while (!rdy && k < 20) begin @(posedge clk); #1; k++; end
        tests++;
        if (rdy !== 1'b1) begin
            fails++; $display("FAIL %s accept: ready=%b required 1", nm, rdy);
            cmd_v = 1'b0; return;
        end
        @(posedge clk); #1;
        cmd_v = 1'b0;
        acc_cyc = cyc;
        if (wr) begin mem_m[s][ix] = d; known[s][ix] = 1; end
        k = 0;
        while (!rv && k < 40) begin
            tests++;
            if (busy !== 1'b1 || rdy !== 1'b0) begin
                fails++; $display("FAIL %s wait: busy=%b ready=%b required busy=1 ready=0", nm, busy, rdy);
            end
            @(posedge clk); #1; k++;
        end
        tests++;
        if (k != lat) begin
            fails++; $display("FAIL %s latency: resp_v at accept+%0d required accept+%0d", nm, k + 1, lat + 1);
        end
        if (rv !== 1'b1) return;
        tests++;
        if (resp[W-1 -: HW] !== hdr) begin
            fails++; $display("FAIL %s header: got %h required %h", nm, resp[W-1 -: HW], hdr);
        end
        if (chk) begin
            tests++;
            if (resp[BW-1:0] !== exp_d) begin
                fails++; $display("FAIL %s data: got %h required %h", nm, resp[63:0], exp_d[63:0]);
            end
        end
        snap = resp;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            tests++;
            if (resp !== snap || rv !== 1'b1 || rdy !== 1'b0 || busy !== 1'b1) begin
                fails++; $display("FAIL %s hold: v=%b ready=%b stable=%b required v=1 ready=0 stable=1",
                                  nm, rv, rdy, resp === snap);
            end
        end
        yumi = 1'b1;
        @(posedge clk); #1;
        yumi = 1'b0;
        tests++;
        if (rv !== 1'b0 || rdy !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL %s release: v=%b ready=%b busy=%b required 0/1/0", nm, rv, rdy, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            #0;
            tests++;
            if (rdy !== 1'b1 || rv !== 1'b0 || resp !== '0 || busy !== 1'b0) begin
                fails++; $display("FAIL reset_state%0d: ready=%b v=%b resp_zero=%b busy=%b required 1/0/1/0",
                                  s, rdy, rv, resp === '0, busy);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_directed();
        logic [BW-1:0] a5, d40;
        sel = 1'b0;
        a5  = {(BW / 8){8'hA5}};
        d40 = rnd_blk();
        xact(4'd1, 40'h80, a5, 5'b00_000, 0, "wr_0x80");
        xact(4'd0, 40'h80, rnd_blk(), {2'd1, 3'd3}, 0, "rd_0x80");
        xact(4'd1, 40'h40, d40, 5'b00_000, 0, "wr_0x40");
        xact(4'd0, 40'h1040, rnd_blk(), 5'b01_101, 0, "rd_alias_0x1040");
        tests++;
        if (mem_m[0][1] !== d40) begin
            fails++; $display("FAIL alias_model: index 1 holds %h required %h", mem_m[0][1][31:0], d40[31:0]);
        end
    endtask

    task automatic test_backpressure();
        sel = 1'b0;
        xact(4'd2, 40'h80, rnd_blk(), 5'b10_010, 10, "backpressure_rd");
        xact(4'd3, 40'h2C0, rnd_blk(), 5'b11_111, 10, "backpressure_uc_wr");
    endtask

    task automatic test_fill();
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            for (int i = 0; i < 64; i++)
                xact(4'd1, {rnd_addr()} & ~40'hFC0 | 40'(i * 64), rnd_blk(), 5'($urandom), 0, "fill");
        end
    endtask

    task automatic test_random();
        logic [3:0] types [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd15};
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            for (int i = 0; i < 60; i++)
                xact(types[$urandom_range(0, 4)], rnd_addr(), rnd_blk(), 5'($urandom),
                     $urandom_range(0, 3), "random");
        end
    endtask

    task automatic test_back_to_back();
        int a1, lat;
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            lat = sel ? 0 : 4;
            xact(4'd0, rnd_addr(), rnd_blk(), 5'($urandom), 0, "b2b_first");
            a1 = acc_cyc;
            xact(4'd2, rnd_addr(), rnd_blk(), 5'($urandom), 0, "b2b_second");
            tests++;
            if (acc_cyc - a1 != lat + 2) begin
                fails++; $display("FAIL b2b_spacing%0d: %0d cycles required %0d", s, acc_cyc - a1, lat + 2);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [BW-1:0] da, db;
        sel = 1'b0;
        da = rnd_blk();
        db = rnd_blk();
        xact(4'd1, 40'h3C0, da, 5'd0, 0, "mid_pre_wr");
        cmd = {4'd1, 40'h400, 3'd6, 5'd0, db};
        cmd_v = 1'b1;
        @(posedge clk); #1;
        cmd_v = 1'b0;
        mem_m[0][16] = db;
        known[0][16] = 1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tests++;
        if (rdy !== 1'b1 || rv !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL mid_reset_state: ready=%b v=%b busy=%b required 1/0/0", rdy, rv, busy);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            tests++;
            if (rv !== 1'b0) begin
                fails++; $display("FAIL mid_reset_no_resp: v=%b required 0", rv);
            end
        end
        xact(4'd0, 40'h400, rnd_blk(), 5'd0, 0, "mid_committed_wr");
        xact(4'd0, 40'h3C0, rnd_blk(), 5'd0, 0, "mid_prior_wr");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_fill();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bp_cce_mem_delay_model.md
Name: bp_cce_mem_delay_model

Overview:
- Cycle-accurate memory endpoint directly downstream of the CCE wrapper's CCE-MEM interface.
- Consumes mem_cmd messages and returns matching mem_resp messages after a programmable fixed latency.
- Backed by a small block-granular storage array.
- Used in the CCE unit bench to close the memory side of the loop. One command is in flight at a time.

Parameters:
- bp_params_p, BP_CFG_FLOWVAR: processor config; supplies paddr_width_p, cce_block_width_p, lce_id_width_p, lce_assoc_p.
- mem_els_p, 64: number of cce_block_width_p-bit blocks stored; power of two, ≥2.
- latency_p, 4: cycles from command accept to response valid, minus one; 0 allowed.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset
- mem_cmd_i  in  cce_mem_msg_width_lp  command message: header {msg_type, addr, size, payload} + data
- mem_cmd_v_i  in  1  command valid
- mem_cmd_ready_o  out  1  ready; handshake is ready/valid
- mem_resp_o  out  cce_mem_msg_width_lp  response message
- mem_resp_v_o  out  1  response valid
- mem_resp_yumi_i  in  1  consumer accepts response; legal only while mem_resp_v_o=1
- busy_o  out  1  high whenever state is not READY (bench idle check)

Behaviour:
- Reset, asynchronous on reset_n_i=0:
  - state=READY, counter=0, held message cleared.
  - mem_cmd_ready_o=1 after reset deasserts; mem_resp_v_o=0; mem_resp_o=0; busy_o=0.
  - Storage is not reset: contents are preserved across reset and undefined at power-up.
- FSM states: READY, WAIT, RESP.
- READY:
  - mem_cmd_ready_o=1.
  - On mem_cmd_v_i & ready, latch header and data.
  - Writes (e_cce_mem_wr, e_cce_mem_uc_wr) update storage at the accept edge.
  - Reads (e_cce_mem_rd, e_cce_mem_uc_rd) capture storage data at the same edge, so read-after-write to the same index sees the new data.
  - counter←latency_p. Next state is WAIT if latency_p>0, else RESP.
- WAIT:
  - ready=0; counter decrements each cycle.
  - When counter==1, next state is RESP. Response valid arrives exactly latency_p+1 cycles after the accept edge.
- RESP:
  - mem_resp_v_o=1; mem_resp_o header equals the latched header, unmodified (msg_type, addr, size, payload incl. lce_id/way).
  - Data field is the captured block for reads and all-zero for writes.
  - Outputs hold stable until mem_resp_yumi_i.
  - On yumi, go to READY. mem_cmd_ready_o asserts the following cycle: no same-cycle resp-accept/cmd-accept bypass. Minimum back-to-back spacing is latency_p+2 cycles.
- Addressing:
  - index = addr[lg_block_bytes +: lg(mem_els_p)]. Upper address bits are ignored, so addresses alias modulo mem_els_p blocks.
  - Block offset bits are ignored.
  - All ops, including uncached, are full-block; size is echoed, not applied.
- Unknown msg_type: treated as a read; no storage update.
- mem_resp_yumi_i asserted when mem_resp_v_o=0 is a bench error. RTL ignores it; an assertion flags it.
- mem_cmd_v_i while not ready: ignored. The upstream holds the command per ready/valid rules.
- Reset mid-operation: any in-flight command is dropped, with no response. A write already committed at accept remains in storage.

Decomposition:
- Shared package bp_me_pkg, reused as is: the cce_mem_msg struct, msg_type enum and width macros.
- New in that package: a localparam-free enum for FSM states, bp_cce_mem_delay_state_e.
- One natural sub-module: bp_cce_mem_delay_storage, a 1R1W synchronous block array (mem_els_p × cce_block_width_p) with write-through read on same-address collision.

Test Plan:
- Reset, then wr addr 0x80 data 0xA5…A5 → resp_v exactly 5 cycles after accept (latency_p=4); same header, data=0; busy_o high for those cycles.
- Then rd addr 0x80, lce_id=1, way=3 → resp data 0xA5…A5; payload lce_id=1, way=3 echoed.
- Alias: mem_els_p=64, 64B blocks; wr 0x40 then rd 0x1040 → returns the 0x40 data.
- Backpressure: hold yumi low 10 cycles in RESP → resp_o and resp_v stable; cmd_ready_o=0 throughout; ready rises the cycle after yumi.
- latency_p=0 build: rd accepted at cycle t → resp_v at t+1; back-to-back reads spaced 2 cycles.
- Reset pulse during WAIT → no response emitted, ready=1 after release; a prior write is still readable.
